// File: rtl/ln_stage1_stats_if.sv
// Sample stream into the LayerNorm stats stage and the replay/statistics bundle out of it.
// master drives samples in and observes results; slave is the stats stage itself.
interface ln_stage1_stats_if;
    logic               i_valid;
    logic signed [8:0]  i_x;
    logic               i_last;
    logic               o_ready;
    logic               o_valid;
    logic signed [8:0]  o_x_norm;
    logic signed [21:0] o_Ex;
    logic [31:0]        o_Ex2;
    logic [1:0]         o_alpha;
    logic [7:0]         o_inv_n;
    logic               o_done;

    modport master (
        output i_valid, i_x, i_last,
        input  o_ready, o_valid, o_x_norm, o_Ex, o_Ex2, o_alpha, o_inv_n, o_done
    );

    modport slave (
        input  i_valid, i_x, i_last,
        output o_ready, o_valid, o_x_norm, o_Ex, o_Ex2, o_alpha, o_inv_n, o_done
    );
endinterface

// File: rtl/ln_stage1_stats.sv
// LayerNorm stage 1: buffers a vector, computes sum/sumsq/alpha/inv_n, replays samples with stats held.
// First replayed sample 10 cycles after the last accept; o_ready drops in CALC/REPLAY, no downstream backpressure.
module ln_stage1_stats #(
    parameter int MAX_N = 64,
    parameter int AW    = 6
) (
    input logic              i_clk,
    input logic              i_rstn,
    ln_stage1_stats_if.slave bus
);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ACC, CALC, REPLAY} state_t;

    state_t             state;
    logic signed [8:0]  buffer [MAX_N];
    logic [CW-1:0]      count;
    logic [CW-1:0]      rd_ptr;
    logic signed [21:0] sum;
    logic [31:0]        sumsq;
    logic [8:0]         maxabs;
    logic [3:0]         calc_cnt;
    logic [8:0]         rem;
    logic [7:0]         quo;

    logic               accept;
    logic               last_acc;
    logic [AW-1:0]      wr_addr;
    logic [8:0]         abs_x;
    logic signed [21:0] x_ext;
    logic [31:0]        sq;
    logic signed [21:0] sum_nxt;
    logic [31:0]        sumsq_nxt;
    logic [8:0]         maxabs_nxt;
    logic [9:0]         rem_sh;
    logic               ge;
    logic [8:0]         rem_sub;

    always_comb begin
        accept     = bus.i_valid & bus.o_ready;
        last_acc   = bus.i_last || (state == ACC && count == CW'(MAX_N - 1));
        wr_addr    = (state == IDLE) ? '0 : count[AW-1:0];
        abs_x      = bus.i_x[8] ? (9'd0 - bus.i_x) : bus.i_x;
        x_ext      = {{13{bus.i_x[8]}}, bus.i_x};
        // |x|^2 == x^2, and squaring the magnitude keeps the product unsigned
        sq         = 32'(abs_x) * 32'(abs_x);
        sum_nxt    = (state == IDLE) ? x_ext : sum + x_ext;
        sumsq_nxt  = (state == IDLE) ? sq : sumsq + sq;
        maxabs_nxt = (state == IDLE || abs_x > maxabs) ? abs_x : maxabs;
        // Restoring division of 256 by N: the dividend has only its MSB set
        rem_sh     = {rem, (calc_cnt == 4'd0)};
        ge         = (rem_sh >= 10'(count));
        rem_sub    = ge ? 9'(rem_sh - 10'(count)) : rem_sh[8:0];
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            buffer[wr_addr] <= bus.i_x;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            sum          <= '0;
            sumsq        <= '0;
            maxabs       <= '0;
            calc_cnt     <= '0;
            rem          <= '0;
            quo          <= '0;
            bus.o_ready  <= 1'b1;
            bus.o_valid  <= 1'b0;
            bus.o_x_norm <= '0;
            bus.o_Ex     <= '0;
            bus.o_Ex2    <= '0;
            bus.o_alpha  <= '0;
            bus.o_inv_n  <= '0;
            bus.o_done   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        count  <= (state == IDLE) ? CW'(1) : count + CW'(1);
                        sum    <= sum_nxt;
                        sumsq  <= sumsq_nxt;
                        maxabs <= maxabs_nxt;
                        if (last_acc) begin
                            state       <= CALC;
                            bus.o_ready <= 1'b0;
                            bus.o_Ex    <= sum_nxt;
                            bus.o_Ex2   <= sumsq_nxt;
                            calc_cnt    <= '0;
                            rem         <= '0;
                            quo         <= '0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                CALC: begin
                    rem      <= rem_sub;
                    quo      <= {quo[6:0], ge};
                    calc_cnt <= calc_cnt + 4'd1;
                    if (calc_cnt == 4'd8) begin
                        // quo[7] is quotient bit 8, set only for N = 1
                        bus.o_inv_n <= quo[7] ? 8'hFF : {quo[6:0], ge};
                        bus.o_alpha <= (maxabs < 9'd64)  ? 2'd0 :
                                       (maxabs < 9'd128) ? 2'd1 : 2'd2;
                        rd_ptr      <= '0;
                        state       <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (rd_ptr == count) begin
                        bus.o_valid <= 1'b0;
                        bus.o_done  <= 1'b0;
                        bus.o_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        bus.o_valid  <= 1'b1;
                        bus.o_x_norm <= buffer[rd_ptr[AW-1:0]];
                        bus.o_done   <= (rd_ptr == count - CW'(1));
                        rd_ptr       <= rd_ptr + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ln_stage1_stats.sv
// Randomized and directed checks of ln_stage1_stats against a plain-arithmetic vector model.
module tb_ln_stage1_stats;
    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;

    ln_stage1_stats_if bus ();

    ln_stage1_stats #(.MAX_N(64), .AW(6)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int vec[$];
    int mark;

    logic signed [21:0] e_ex;
    logic [31:0]        e_ex2;
    logic [1:0]         e_alpha;
    logic [7:0]         e_inv;

    task automatic model();
        int s  = 0;
        int sq = 0;
        int mx = 0;
        int a;
        foreach (vec[i]) begin
            a  = (vec[i] < 0) ? -vec[i] : vec[i];
            s  += vec[i];
            sq += vec[i] * vec[i];
            if (a > mx) mx = a;
        end
        e_ex    = 22'(s);
        e_ex2   = 32'(sq);
        e_alpha = (mx < 64) ? 2'd0 : (mx < 128) ? 2'd1 : 2'd2;
        e_inv   = (vec.size() == 1) ? 8'd255 : 8'(256 / vec.size());
    endtask

    task automatic send_vec(input bit use_last, input int min_gap, input int max_gap);
        int n = vec.size();
        bit acc;
        for (int i = 0; i < n; i++) begin
            acc         = 1'b0;
            bus.i_valid = 1'b1;
            bus.i_x     = 9'(vec[i]);
            bus.i_last  = use_last && (i == n - 1);
            for (int t = 0; t < 20 && !acc; t++) begin
                acc = bus.o_ready;
                @(negedge i_clk);
            end
            vectors++;
            if (!acc) begin
                miscompares++;
                $display("FAIL accept_timeout sample %0d: o_ready stayed %0b, required 1", i, bus.o_ready);
            end
            bus.i_valid = 1'b0;
            bus.i_last  = 1'b0;
            if (i == n - 1) mark = cyc;
            else repeat ($urandom_range(min_gap, max_gap)) @(negedge i_clk);
        end
    endtask

    task automatic run_and_check(input bit junk);
        int n   = vec.size();
        int k   = 0;
        bit fin = 1'b0;
        logic signed [8:0] ex_x;
        model();
        if (junk) begin
            bus.i_valid = 1'b1;
            bus.i_x     = 9'($urandom);
        end
        for (int c = 0; c < 2 * n + 40 && !fin; c++) begin
            @(negedge i_clk);
            if (bus.o_valid) begin
                if (k == 0) begin
                    vectors++;
                    if (cyc - mark !== 10) begin
                        miscompares++;
                        $display("FAIL first_valid_latency: got %0d cycles, required 10", cyc - mark);
                    end
                end
                vectors++;
                if (k >= n) begin
                    miscompares++;
                    $display("FAIL extra_replay: element %0d seen, required only %0d", k, n);
                end else begin
                    ex_x = 9'(vec[k]);
                    if (bus.o_x_norm !== ex_x) begin
                        miscompares++;
                        $display("FAIL x_norm[%0d]: got %0d, required %0d", k, bus.o_x_norm, ex_x);
                    end
                end
                vectors++;
                if (bus.o_Ex !== e_ex || bus.o_Ex2 !== e_ex2 || bus.o_alpha !== e_alpha || bus.o_inv_n !== e_inv) begin
                    miscompares++;
                    $display("FAIL stats[%0d]: got Ex=%0d Ex2=%0d alpha=%0d inv_n=%0d, required %0d %0d %0d %0d",
                             k, bus.o_Ex, bus.o_Ex2, bus.o_alpha, bus.o_inv_n, e_ex, e_ex2, e_alpha, e_inv);
                end
                vectors++;
                if (bus.o_done !== (k == n - 1)) begin
                    miscompares++;
                    $display("FAIL done[%0d]: got %0b, required %0b", k, bus.o_done, (k == n - 1));
                end
                if (k == n - 1) begin
                    vectors++;
                    if (cyc - mark !== 9 + n) begin
                        miscompares++;
                        $display("FAIL done_latency: got %0d cycles, required %0d", cyc - mark, 9 + n);
                    end
                end
                vectors++;
                if (bus.o_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ready_in_replay: got %0b, required 0", bus.o_ready);
                end
                k++;
            end else begin
                vectors++;
                if (bus.o_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_without_valid: got %0b, required 0", bus.o_done);
                end
                if (k > 0) begin
                    fin = 1'b1;
                    vectors++;
                    if (k !== n) begin
                        miscompares++;
                        $display("FAIL replay_count: got %0d, required %0d", k, n);
                    end
                    vectors++;
                    if (bus.o_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL ready_after_replay: got %0b, required 1", bus.o_ready);
                    end
                    vectors++;
                    if (bus.o_Ex !== e_ex || bus.o_Ex2 !== e_ex2) begin
                        miscompares++;
                        $display("FAIL stats_hold: got Ex=%0d Ex2=%0d, required %0d %0d", bus.o_Ex, bus.o_Ex2, e_ex, e_ex2);
                    end
                end
            end
            if (!fin && junk) begin
                bus.i_valid = 1'b1;
                bus.i_x     = 9'($urandom);
                bus.i_last  = 1'($urandom);
            end else begin
                bus.i_valid = 1'b0;
                bus.i_last  = 1'b0;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        if (!fin) begin
            vectors++;
            miscompares++;
            $display("FAIL replay_timeout: saw %0d elements, required %0d then idle", k, n);
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        vectors++;
        if (bus.o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %0b, required 1", bus.o_ready);
        end
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_x_norm !== 9'sd0) begin
            miscompares++;
            $display("FAIL reset_stream: got valid=%0b done=%0b x=%0d, required 0 0 0", bus.o_valid, bus.o_done, bus.o_x_norm);
        end
        vectors++;
        if (bus.o_Ex !== 22'sd0 || bus.o_Ex2 !== 32'd0 || bus.o_alpha !== 2'd0 || bus.o_inv_n !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_stats: got %0d %0d %0d %0d, required all 0", bus.o_Ex, bus.o_Ex2, bus.o_alpha, bus.o_inv_n);
        end
    endtask

    task automatic test_basic();
        vec = '{44, -81, -11, 64, -61, 123, 67, -25};
        send_vec(1'b1, 0, 0);
        run_and_check(1'b0);
        vectors++;
        if (bus.o_Ex !== 22'sd120 || bus.o_Ex2 !== 32'd36678 || bus.o_alpha !== 2'd1 || bus.o_inv_n !== 8'd32) begin
            miscompares++;
            $display("FAIL basic_n8: got %0d %0d %0d %0d, required 120 36678 1 32", bus.o_Ex, bus.o_Ex2, bus.o_alpha, bus.o_inv_n);
        end
    endtask

    task automatic test_single();
        vec = '{-256};
        send_vec(1'b1, 0, 0);
        run_and_check(1'b0);
        vectors++;
        if (bus.o_Ex !== -22'sd256 || bus.o_Ex2 !== 32'd65536 || bus.o_alpha !== 2'd2 || bus.o_inv_n !== 8'd255) begin
            miscompares++;
            $display("FAIL single_n1: got %0d %0d %0d %0d, required -256 65536 2 255", bus.o_Ex, bus.o_Ex2, bus.o_alpha, bus.o_inv_n);
        end
    endtask

    task automatic test_max_len();
        vec = {};
        repeat (64) vec.push_back(3);
        send_vec(1'b0, 0, 0);
        run_and_check(1'b0);
        vectors++;
        if (bus.o_Ex !== 22'sd192 || bus.o_Ex2 !== 32'd576 || bus.o_alpha !== 2'd0 || bus.o_inv_n !== 8'd4) begin
            miscompares++;
            $display("FAIL max_len: got %0d %0d %0d %0d, required 192 576 0 4", bus.o_Ex, bus.o_Ex2, bus.o_alpha, bus.o_inv_n);
        end
    endtask

    task automatic test_busy_ignore();
        vec = {};
        repeat (12) vec.push_back(int'($urandom_range(0, 511)) - 256);
        send_vec(1'b1, 0, 1);
        run_and_check(1'b1);
        vec = '{5, -7, 9};
        send_vec(1'b1, 0, 0);
        run_and_check(1'b0);
    endtask

    task automatic test_reset_mid();
        int k   = 0;
        bit hit = 1'b0;
        vec = '{44, -81, -11, 64, -61, 123, 67, -25};
        send_vec(1'b1, 0, 0);
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge i_clk);
            if (bus.o_valid) begin
                if (k == 3) begin
                    hit    = 1'b1;
                    i_rstn = 1'b0;
                    #1;
                    vectors++;
                    if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_x_norm !== 9'sd0 || bus.o_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL midreset_stream: got valid=%0b done=%0b x=%0d ready=%0b, required 0 0 0 1",
                                 bus.o_valid, bus.o_done, bus.o_x_norm, bus.o_ready);
                    end
                    vectors++;
                    if (bus.o_Ex !== 22'sd0 || bus.o_Ex2 !== 32'd0 || bus.o_alpha !== 2'd0 || bus.o_inv_n !== 8'd0) begin
                        miscompares++;
                        $display("FAIL midreset_stats: got %0d %0d %0d %0d, required all 0", bus.o_Ex, bus.o_Ex2, bus.o_alpha, bus.o_inv_n);
                    end
                end
                k++;
            end
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL midreset_reach: replay element 3 not seen, got %0d elements", k);
        end
        repeat (3) begin
            @(negedge i_clk);
            vectors++;
            if (bus.o_done !== 1'b0 || bus.o_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_hold: got valid=%0b done=%0b, required 0 0", bus.o_valid, bus.o_done);
            end
        end
        i_rstn = 1'b1;
        @(negedge i_clk);
        vectors++;
        if (bus.o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %0b, required 1", bus.o_ready);
        end
        vec = '{10, -10, 20, -20};
        send_vec(1'b1, 0, 0);
        run_and_check(1'b0);
        vectors++;
        if (bus.o_Ex !== 22'sd0 || bus.o_Ex2 !== 32'd1000 || bus.o_inv_n !== 8'd64) begin
            miscompares++;
            $display("FAIL after_reset_n4: got %0d %0d %0d, required 0 1000 64", bus.o_Ex, bus.o_Ex2, bus.o_inv_n);
        end
    endtask

    task automatic test_gaps();
        vec = '{1, 2, 3, 4, 5};
        send_vec(1'b1, 1, 1);
        run_and_check(1'b0);
        vectors++;
        if (bus.o_Ex !== 22'sd15 || bus.o_Ex2 !== 32'd55 || bus.o_inv_n !== 8'd51 || bus.o_alpha !== 2'd0) begin
            miscompares++;
            $display("FAIL gaps_n5: got %0d %0d %0d %0d, required 15 55 51 0", bus.o_Ex, bus.o_Ex2, bus.o_inv_n, bus.o_alpha);
        end
    endtask

    task automatic test_random();
        int n;
        bit use_last;
        for (int v = 0; v < 10; v++) begin
            n = $urandom_range(1, 64);
            vec = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0:       vec.push_back(int'($urandom_range(0, 127)) - 64);
                    1:       vec.push_back(int'($urandom_range(0, 255)) - 128);
                    default: vec.push_back(int'($urandom_range(0, 511)) - 256);
                endcase
            end
            use_last = (n < 64) ? 1'b1 : 1'($urandom);
            send_vec(use_last, 0, 2);
            run_and_check(1'($urandom));
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        bus.i_last  = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_max_len();
        test_busy_ignore();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ln_stage1_stats.md
Name: ln_stage1_stats

Overview:
- Front-end statistics and replay stage of the LayerNorm pipeline; transmitting end of the Stage2 input interface.
- Accepts one vector of up to MAX_N signed 9-bit samples and buffers it.
- Computes the sum (Ex), the sum of squares (Ex2), the compression shift (alpha) and the reciprocal length (inv_n).
- Replays the buffered samples as o_x_norm with all statistics held stable, in the exact form Stage2 consumes.

Parameters:
- MAX_N, 64, maximum vector length (power of two, at most 256).
- AW, 6, address width of the sample buffer (log2 MAX_N).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- i_x  in  9  signed input sample.
- i_last  in  1  marks the final sample of the vector; qualified by i_valid.
- o_ready  out  1  block can accept a sample.
- o_valid  out  1  o_x_norm valid; drives Stage2 i_valid.
- o_x_norm  out  9  signed replayed sample.
- o_Ex  out  22  signed sum of samples.
- o_Ex2  out  32  unsigned sum of squares.
- o_alpha  out  2  compression shift.
- o_inv_n  out  8  floor(256/N), saturated.
- o_done  out  1  one-cycle pulse with the last replayed sample.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0 except o_ready. State goes to IDLE, and the count and accumulators clear.
- Reset mid-operation: same effect in any state. The vector is discarded and no o_done is issued.
- Accept: a sample is taken when i_valid & o_ready. o_ready = 1 only in IDLE and ACC. i_valid in CALC or REPLAY is ignored and the sample is dropped.
- IDLE: on the first accept, store the sample at buffer[0], set the sum to x, sumsq to x*x, maxabs to |x|, count to 1, then go to ACC. If that sample has i_last, go directly to CALC.
- ACC: each accept writes buffer[count], then count++, sum += x, sumsq += x*x and maxabs = max(maxabs, |x|).
- Leaving ACC: go to CALC when the accepted sample has i_last, or when count reaches MAX_N. The MAX_N-th sample is treated as last even when i_last = 0.
- Widths: x*x is a 17-bit unsigned product, zero-extended into the 32-bit sum. The sum is sign-extended into 22 bits. Neither can overflow for MAX_N ≤ 256.
- CALC: lasts exactly 9 cycles.
  - inv_n is computed by restoring division of 256 by N (one quotient bit per cycle).
  - If the result exceeds 255 (N = 1), o_inv_n = 255.
  - o_alpha = 0 if maxabs < 64, 1 if < 128, else 2. Value 3 is never produced.
  - o_Ex and o_Ex2 are loaded on CALC entry.
- REPLAY: starts the cycle after CALC.
  - For k = 0..N-1, one sample per cycle with no gaps: o_valid = 1 and o_x_norm = buffer[k].
  - o_Ex, o_Ex2, o_alpha and o_inv_n stay constant throughout REPLAY.
  - o_done = 1 only together with k = N-1.
- Leaving REPLAY: the next cycle clears o_valid and o_done to 0 and returns to IDLE. Statistic outputs hold their values until the next CALC.
- Latency: if the last sample is accepted on edge t, the first o_valid is seen after edge t+10. o_done is seen after edge t+9+N.
- Backpressure: the downstream side has none. Throughput is one vector per N + 1 + 9 + N cycles.

Test Plan:
- N = 8 vector: stream 44, -81, -11, 64, -61, 123, 67, -25 with i_last on -25 → o_Ex = 120, o_Ex2 = 36678, o_alpha = 1, o_inv_n = 32. Replay is the same 8 values in order on 8 consecutive o_valid cycles. o_done is asserted with -25, and first o_valid comes 10 cycles after the last accept.
- N = 1, sample -256 → o_Ex = -256, o_Ex2 = 65536, o_alpha = 2, o_inv_n = 255 (saturated), single replay cycle with o_done = 1.
- 64 samples of value 3 with i_last never asserted → CALC is forced after the 64th sample, o_Ex = 192, o_Ex2 = 576, o_alpha = 0, o_inv_n = 4. Replay has 64 cycles.
- i_valid held high with new data during CALC/REPLAY → o_ready = 0 and those samples do not affect o_Ex, o_Ex2 or the replay contents. The next vector after returning to IDLE computes correctly from zeroed accumulators.
- Assert i_rstn = 0 at replay element 3 of the N = 8 vector → all outputs go to 0 immediately (asynchronous) and no o_done is issued. After release, o_ready = 1 and a new N = 4 vector 10, -10, 20, -20 gives o_Ex = 0, o_Ex2 = 1000, o_inv_n = 64.
- Samples with gaps in i_valid (one idle cycle between each of 5 samples 1..5) → o_Ex = 15, o_Ex2 = 55, o_inv_n = 51, o_alpha = 0.
